// File: rtl/filter_ctrl_5x5.sv
// filter_ctrl_5x5
// Timing and control generator for the 5x5 line-buffer data-align stage.
// Tracks the input column and line position, drives the line-memory
// read/write enables and addresses, and drives the one-hot line-align and
// line-padding selects, so that the 5x5 window is centred on line n-2.
// After the last input line it generates two flush lines of its own, so
// that the bottom two output rows are emitted.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_frame_start       one-cycle pulse: samples i_width/i_height, restarts
//   i_width, i_height   active pixels per line / active lines per frame
//   i_input_de          input pixel valid (shared with the align stage)
//   o_mem_de            read-cycle valid for the align stage
//   o_mem_raddr         read address (combinational, current column)
//   o_mem_waddr         write address (registered, previous column)
//   o_mem_*_wen/_ren    Y/U/V line-memory write and read enables
//   o_aln_ln_y          one-hot index of the oldest line memory
//   o_pad_ln_y          one-hot line-padding select
//   o_busy              frame in progress
//   o_frame_done        one-cycle pulse after the second flush line
//
// state  | meaning
// IDLE   | waiting for i_frame_start
// ACTIVE | input lines arriving on i_input_de
// GAP    | FLUSH_GAP idle cycles before each flush line
// FLUSH  | self-generated line of width read cycles
// DONE   | one cycle, pulses o_frame_done
module filter_ctrl_5x5 #(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_Y_WIDTH    = 4,
  parameter int MEM_U_WIDTH    = 2,
  parameter int MEM_V_WIDTH    = 2,
  parameter int MEM_ADDR_WIDTH = 11,
  parameter int FLUSH_GAP      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_frame_start,
  input  logic [MEM_ADDR_WIDTH-1:0] i_width,
  input  logic [10:0]               i_height,
  input  logic                      i_input_de,
  output logic                      o_mem_de,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_raddr,
  output logic [MEM_Y_WIDTH-1:0]    o_mem_y_wen,
  output logic                      o_mem_y_ren,
  output logic [MEM_U_WIDTH-1:0]    o_mem_u_wen,
  output logic [MEM_U_WIDTH-1:0]    o_mem_u_ren,
  output logic [MEM_V_WIDTH-1:0]    o_mem_v_wen,
  output logic [MEM_V_WIDTH-1:0]    o_mem_v_ren,
  output logic [3:0]                o_aln_ln_y,
  output logic [3:0]                o_pad_ln_y,
  output logic                      o_busy,
  output logic                      o_frame_done
);

  localparam int CW = MEM_ADDR_WIDTH;
  localparam int NW = 12;  // line index runs up to height+2
  localparam int GW = $clog2(FLUSH_GAP);

  generate
    if (FLUSH_GAP < 4) begin : g_gap_chk
      $error("FLUSH_GAP must be at least 4");
    end
    if (DATA_WIDTH < 1) begin : g_dw_chk
      $error("DATA_WIDTH must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_GAP    = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        width_q;
  logic [10:0]          height_q;
  logic [CW-1:0]        col;
  logic [NW-1:0]        n;
  logic [GW-1:0]        gap_cnt;
  logic                 flush_one;  // first flush line already emitted
  logic                 de_d;
  logic [MEM_Y_WIDTH-1:0] y_wen_q;
  logic [MEM_U_WIDTH-1:0] u_wen_q;
  logic [MEM_V_WIDTH-1:0] v_wen_q;
  logic [CW-1:0]        waddr_q;

  logic          de_fall;
  logic          last_line;
  logic          pix_acc;
  logic          flush_eol;
  logic [NW-1:0] h_m1, h_m2, r_ctr;

  assign h_m1      = {1'b0, height_q} - NW'(1);
  assign h_m2      = {1'b0, height_q} - NW'(2);
  assign r_ctr     = n - NW'(2);
  assign de_fall   = (state == S_ACTIVE) && de_d && !i_input_de;
  assign last_line = (n == h_m1);
  assign pix_acc   = (state == S_ACTIVE) && i_input_de && (col != width_q);
  assign flush_eol = (state == S_FLUSH) &&
                     (({1'b0, col} + 1'b1) >= {1'b0, width_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_frame_start) begin
      state_nxt = S_ACTIVE;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_IDLE;
        S_ACTIVE: if (de_fall && last_line) state_nxt = S_GAP;
        S_GAP:    if (gap_cnt == '0) state_nxt = S_FLUSH;
        S_FLUSH:  if (flush_eol) state_nxt = flush_one ? S_DONE : S_GAP;
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q   <= '0;
      height_q  <= '0;
      col       <= '0;
      n         <= '0;
      gap_cnt   <= '0;
      flush_one <= 1'b0;
      de_d      <= 1'b0;
      y_wen_q   <= '0;
      u_wen_q   <= '0;
      v_wen_q   <= '0;
      waddr_q   <= '0;
    end else if (i_frame_start) begin
      width_q   <= i_width;
      height_q  <= i_height;
      col       <= '0;
      n         <= '0;
      gap_cnt   <= '0;
      flush_one <= 1'b0;
      de_d      <= 1'b0;
      y_wen_q   <= '0;
      u_wen_q   <= '0;
      v_wen_q   <= '0;
    end else begin
      de_d    <= (state == S_ACTIVE) && i_input_de;
      y_wen_q <= '0;
      u_wen_q <= '0;
      v_wen_q <= '0;
      case (state)
        S_ACTIVE: begin
          // Write strobes lag the accepted pixel by one cycle.
          if (pix_acc) begin
            col     <= col + 1'b1;
            waddr_q <= col;
            y_wen_q <= MEM_Y_WIDTH'(1) << n[1:0];
            u_wen_q <= n[0] ? '0 : (MEM_U_WIDTH'(1) << n[1]);
            v_wen_q <= n[0] ? '0 : (MEM_V_WIDTH'(1) << n[1]);
          end
          if (de_fall) begin
            col <= '0;
            n   <= n + 1'b1;
            if (last_line) gap_cnt <= GW'(FLUSH_GAP - 1);
          end
        end
        S_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        S_FLUSH: begin
          if (flush_eol) begin
            col       <= '0;
            n         <= n + 1'b1;
            flush_one <= 1'b1;
            gap_cnt   <= GW'(FLUSH_GAP - 1);
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy       = (state != S_IDLE);
    o_frame_done = (state == S_DONE);
    o_mem_de     = ((state == S_ACTIVE) && i_input_de && (n >= NW'(2))) ||
                   (state == S_FLUSH);
    o_mem_raddr  = col;
    o_mem_y_ren  = o_mem_de;
    o_mem_u_ren  = {MEM_U_WIDTH{o_mem_de}};
    o_mem_v_ren  = {MEM_V_WIDTH{o_mem_de}};
    o_mem_waddr  = waddr_q;
    o_mem_y_wen  = y_wen_q;
    o_mem_u_wen  = u_wen_q;
    o_mem_v_wen  = v_wen_q;
    o_aln_ln_y   = '0;
    o_pad_ln_y   = '0;
    if (o_busy) begin
      o_aln_ln_y = 4'b0001 << n[1:0];
      // Top-edge bits take precedence over bottom-edge bits.
      if (n >= NW'(2)) begin
        if (r_ctr == NW'(0))      o_pad_ln_y = 4'b0001;
        else if (r_ctr == NW'(1)) o_pad_ln_y = 4'b0010;
        else if (r_ctr == h_m1)   o_pad_ln_y = 4'b0100;
        else if (r_ctr == h_m2)   o_pad_ln_y = 4'b1000;
      end
    end
  end

endmodule

// File: doc/filter_ctrl_5x5.md
Name: filter_ctrl_5x5

Overview:
- Timing and control generator for the 5x5 line-buffer data-align stage.
- Sits directly upstream of that stage. Tracks input column and line position and drives the line-memory write/read enables and addresses.
- Drives the one-hot line-align and line-padding selects, so the 5x5 window is always centred on line n-2.
- After the last input line, self-generates two flush lines so the bottom two output rows are emitted.

Parameters:
- DATA_WIDTH, 8, pixel width (kept for stage-parameter consistency; no data path here).
- MEM_Y_WIDTH, 4, number of Y line memories.
- MEM_U_WIDTH, 2, number of U line memories.
- MEM_V_WIDTH, 2, number of V line memories.
- MEM_ADDR_WIDTH, 11, line-memory address width (max width 2048).
- FLUSH_GAP, 8, idle cycles before and between flush lines (minimum 4).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- i_frame_start  input  1  one-cycle pulse; samples size, clears counters.
- i_width  input  MEM_ADDR_WIDTH  active pixels per line; sampled on i_frame_start.
- i_height  input  11  active lines per frame, >=5; sampled on i_frame_start.
- i_input_de  input  1  input pixel valid; shared with the align stage.
- o_mem_de  output  1  read-cycle valid for the align stage.
- o_mem_waddr  output  MEM_ADDR_WIDTH  write address.
- o_mem_raddr  output  MEM_ADDR_WIDTH  read address.
- o_mem_y_wen  output  MEM_Y_WIDTH  one-hot Y memory write enable.
- o_mem_y_ren  output  1  Y read enable.
- o_mem_u_wen  output  MEM_U_WIDTH  U memory write enable.
- o_mem_u_ren  output  MEM_U_WIDTH  U read enables.
- o_mem_v_wen  output  MEM_V_WIDTH  V memory write enable.
- o_mem_v_ren  output  MEM_V_WIDTH  V read enables.
- o_aln_ln_y  output  4  one-hot, oldest-line memory index.
- o_pad_ln_y  output  4  one-hot line-padding select.
- o_busy  output  1  frame in progress.
- o_frame_done  output  1  one-cycle pulse after the last flush line.

Behaviour:
- Reset (rst=1, asynchronous): all outputs and registered state go to 0; state = IDLE.
- States and transitions:
  - IDLE: i_frame_start -> ACTIVE.
  - ACTIVE: falling edge of i_input_de on line i_height-1 -> GAP.
  - GAP: after FLUSH_GAP cycles -> FLUSH.
  - FLUSH: after width cycles -> GAP if only one flush line is done, otherwise -> DONE.
  - DONE: one cycle, pulses o_frame_done -> IDLE.
- o_busy = 1 in every state except IDLE.
- i_frame_start in any state: restarts ACTIVE with line n=0, col=0. No done pulse is issued for the aborted frame.
- Counters:
  - col increments on each i_input_de (ACTIVE) or each FLUSH cycle; clears at end of line.
  - n increments at the end of each line, both input and flush lines.
  - i_input_de while col==width is ignored; col saturates.
- Read side, combinational in the same cycle as i_input_de:
  - o_mem_raddr = col.
  - o_mem_de = (ACTIVE & i_input_de & n>=2) | FLUSH.
  - o_mem_y_ren = o_mem_de.
  - o_mem_u_ren = o_mem_v_ren = {2{o_mem_de}}.
- Write side, registered one cycle after the i_input_de cycle so it aligns with the stage's input delay register:
  - o_mem_waddr = previous col.
  - o_mem_y_wen = onehot(n mod 4).
  - o_mem_u_wen = o_mem_v_wen = onehot((n/2) mod 2), only when n is even.
  - No writes during FLUSH.
- o_aln_ln_y = onehot(n mod 4), held constant for the whole line. The centre row is n-2.
- o_pad_ln_y is set from centre row r = n-2:
  - bit0 when r==0.
  - bit1 when r==1.
  - bit2 when r==height-1.
  - bit3 when r==height-2.
  - otherwise 0.
  - When both a top and a bottom bit qualify, the lower bit index wins.
- Input requirement: at least 4 blanking cycles between input lines, so the downstream column flush fits.
- Height changes take effect only at the next i_frame_start.

Test Plan:
- rst pulsed mid-line (width=16, height=8, n=3, col=7) -> all outputs 0 next cycle; no o_mem_de until the next i_frame_start.
- width=8, height=6, lines n=0..1 -> o_mem_de stays 0. o_mem_y_wen = 0001 then 0010, each one cycle after i_input_de. o_mem_waddr runs 0..7.
- Same frame, lines n=2..5:
  - o_mem_de is high for 8 cycles per line.
  - o_aln_ln_y = 0100, 1000, 0001, 0010.
  - o_pad_ln_y = 0001, 0010, 0000, 0000.
- After the last input line with FLUSH_GAP=8:
  - 8 idle cycles, then o_mem_de high for 8 cycles with pad 1000 and aln 0100.
  - 8 idle cycles, then 8 cycles with pad 0100 and aln 1000.
  - Then o_frame_done pulses once and o_busy falls.
- Chroma, height=6 -> o_mem_u_wen = 01, 00, 10, 00, 01, 00 on n=0..5; o_mem_v_wen is identical.
- i_frame_start asserted during the second flush line -> no o_frame_done pulse; n=0 and col=0 on the next cycle; new width/height sampled.
